// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM encoding, default parameters and sizing helper for the data memory
package dmem_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ADDR_W = 8;

    // One extra bit beyond the index width so the counter can represent DEPTH itself
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dmem_init_gen.sv
// dmem_init_gen: maps the init counter to the power-on word (ascending lower half, negated offsets upper half)
module dmem_init_gen
    import dmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CW     = cnt_width(DEF_DEPTH)
) (
    input  logic [CW-1:0]     idx_i,
    output logic [DATA_W-1:0] word_o
);

    localparam int HALF = DEPTH / 2;

    logic [CW-1:0] off;

    assign off    = idx_i - CW'(HALF);
    assign word_o = (idx_i >= CW'(HALF)) ? DATA_W'(0) - DATA_W'(off) : DATA_W'(idx_i);

endmodule

// File: rtl/param_data_memory.sv
// param_data_memory: single-port data memory that self-initialises after reset, then serves registered reads and writes
module param_data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [DATA_W-1:0] ReadData,
    output logic              ReadValid,
    output logic              Busy,
    output logic              AddrErr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 4");
    end
    if (ADDR_W < AW) begin : g_bad_addr_w
        $error("ADDR_W too narrow to address DEPTH words");
    end

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              aerr_q, aerr_d;
    logic [DATA_W-1:0] init_word, wdata;
    logic [AW-1:0]     uaddr, waddr;
    logic              last, in_range, accept, rd_ok, wr_ok, we;

    dmem_init_gen #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_init_gen (
        .idx_i (cnt_q),
        .word_o(init_word)
    );

    // Upper address bits beyond the index width flag an out-of-range request
    assign uaddr    = Address[AW-1:0];
    assign in_range = (Address >> AW) == '0;
    assign accept   = !reset && state_q == READY;
    assign rd_ok    = accept && MemRead && in_range;
    assign wr_ok    = accept && MemWrite && in_range;
    assign last     = cnt_q == CW'(DEPTH - 1);

    // Init walks the counter once through every word, then hands over to READY
    always_comb begin
        state_d = (state_q == INIT && last) ? READY : state_q;
        cnt_d   = (state_q == INIT && !last) ? cnt_q + CW'(1) : '0;
    end

    // Single write port shared between the init sequence and user writes; reset blocks both
    always_comb begin
        we       = !reset && (state_q == INIT || wr_ok);
        waddr    = (state_q == INIT) ? cnt_q[AW-1:0] : uaddr;
        wdata    = (state_q == INIT) ? init_word : WriteData;
        rdata_d  = rd_ok ? mem_q[uaddr] : rdata_q;
        rvalid_d = rd_ok;
        aerr_d   = accept && (MemRead || MemWrite) && !in_range;
    end

    // FSM state and init counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered read data and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            aerr_q   <= aerr_d;
        end
    end

    // Storage array; a same-edge read sees the old word because both sample before update
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign ReadData  = rdata_q;
    assign ReadValid = rvalid_q;
    assign AddrErr   = aerr_q;
    assign Busy      = state_q == INIT;

endmodule

// File: tb/tb_param_data_memory.sv
// tb_param_data_memory: randomized checks of the data memory against an array-based reference model
module tb_param_data_memory;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  Address = '0;
    logic [7:0]  WriteData = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [7:0]  ReadData;
    logic        ReadValid, Busy, AddrErr;

    logic        reset2 = 1'b0;
    logic [5:0]  Address2 = '0;
    logic [15:0] WriteData2 = '0;
    logic        MemRead2 = 1'b0;
    logic        MemWrite2 = 1'b0;
    logic [15:0] ReadData2;
    logic        ReadValid2, Busy2, AddrErr2;

    int n_checks = 0;
    int n_pass = 0;
    int err2_cnt = 0;
    bit en2 = 1'b0;

    logic [7:0] model [DEPTH];
    int         init_left = 0;
    logic [7:0] e_rd = '0;
    bit         e_rv = 1'b0;
    bit         e_err = 1'b0;

    always #5 clk = ~clk;

    param_data_memory dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData),
        .ReadValid(ReadValid), .Busy(Busy), .AddrErr(AddrErr)
    );

    param_data_memory #(.DATA_W(16), .DEPTH(64), .ADDR_W(6)) dut2 (
        .clk(clk), .reset(reset2), .Address(Address2), .WriteData(WriteData2),
        .MemRead(MemRead2), .MemWrite(MemWrite2), .ReadData(ReadData2),
        .ReadValid(ReadValid2), .Busy(Busy2), .AddrErr(AddrErr2)
    );

    always @(posedge clk) if (en2 && AddrErr2 === 1'b1) err2_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] pat8(input int i);
        return (i < DEPTH / 2) ? 8'(i) : 8'((256 - (i - DEPTH / 2)) % 256);
    endfunction

    function automatic logic [15:0] pat16(input int i);
        return (i < 32) ? 16'(i) : 16'((65536 - (i - 32)) % 65536);
    endfunction

    task automatic step(input bit rst, input bit rd, input bit wr, input int addr, input int wd);
        reset = rst; MemRead = rd; MemWrite = wr; Address = 8'(addr); WriteData = 8'(wd);
        @(posedge clk); #1;
        if (rst) begin
            init_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) model[i] = pat8(i);
            e_rd = '0; e_rv = 0; e_err = 0;
        end else if (init_left > 0) begin
            init_left--;
            e_rv = 0; e_err = 0;
        end else begin
            e_rv  = rd && addr < DEPTH;
            e_err = (rd || wr) && addr >= DEPTH;
            if (e_rv) e_rd = model[addr];
            if (wr && addr < DEPTH) model[addr] = 8'(wd);
        end
        check("busy", 32'(Busy), 32'(init_left > 0));
        check("rvalid", 32'(ReadValid), 32'(e_rv));
        check("addrerr", 32'(AddrErr), 32'(e_err));
        check("rdata", 32'(ReadData), 32'(e_rd));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        step(1, 0, 0, 0, 0);
        for (int c = 0; c < DEPTH; c++)
            step(0, 0, c == 10, 3, 8'h77);
        foreach (model[i]) check("initpat", 32'(model[i]), 32'(pat8(i)));
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 15, 0);
        step(0, 1, 0, 16, 0);
        step(0, 1, 0, 17, 0);
        step(0, 1, 0, 31, 0);
        step(0, 1, 0, 3, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 5, 8'hA5);
        step(0, 1, 0, 5, 0);
        step(0, 1, 1, 5, 8'h3C);
        step(0, 1, 0, 5, 0);
        step(0, 1, 0, 40, 0);
        step(0, 0, 1, 40, 8'h99);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 8, 0);
        step(0, 1, 0, 8, 0);
        for (int k = 0; k < 300; k++) begin
            int sel = $urandom_range(0, 3);
            step(0, sel[0], sel[1], $urandom_range(0, 47), $urandom_range(0, 255));
        end
        step(1, 0, 0, 0, 0);
        for (int c = 0; c < 20; c++) step(0, 1, 1, c, 8'h55);
        for (int c = 0; c < 3; c++) step(1, 1, 1, 4, 8'h66);
        for (int c = 0; c < DEPTH; c++) step(0, c[0], 1, c, 8'h11);
        for (int a = 0; a < DEPTH; a++) step(0, 1, 0, a, 0);
        step(0, 0, 0, 0, 0);

        reset2 = 1'b1;
        @(posedge clk); #1;
        reset2 = 1'b0;
        en2 = 1'b1;
        check("busy2_after_reset", 32'(Busy2), 32'd1);
        cnt = 0;
        while (Busy2 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("init64_cycles", cnt, 64);
        MemRead2 = 1'b1;
        for (int a = 0; a < 64; a++) begin
            Address2 = 6'(a);
            @(posedge clk); #1;
            check("rvalid2", 32'(ReadValid2), 32'd1);
            check("rdata2", 32'(ReadData2), 32'(pat16(a)));
        end
        MemRead2 = 1'b0;
        @(posedge clk); #1;
        check("rvalid2_idle", 32'(ReadValid2), 32'd0);
        check("addrerr2_count", err2_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
